uart_tx_periph: RTL and testbench
=================================

// Module: uart_tx_periph
// PURPOSE
// - Memory-mapped UART transmitter; the responder on the CPU data bus (ce/we/addr/sel/data), beside data_ram.
// - CPU writes bytes into a TX FIFO; the block serialises them 8N1 on txd_o at a programmable bit period.
// - tx_int_o is a level interrupt for one bit of the CPU int_i vector.
// PARAMETERS
// - FIFO_DEPTH   8        TX FIFO entries; power of 2, >= 2
// - CNT_W        4        FIFO level width = log2(FIFO_DEPTH)+1
// - DIV_RESET    16'd434  reset value of BAUDDIV (50 MHz / 115200)
// PORTS
// - clk        in   1   system clock, all state on posedge
// - rst        in   1   asynchronous reset, active-high
// - ce         in   1   bus select, already decoded by the SoC
// - we         in   1   1 = write, 0 = read
// - addr       in   32  byte address; only addr[3:2] decoded
// - sel        in   4   byte enables for writes
// - data_i     in   32  write data from the CPU
// - data_o     out  32  read data to the CPU, combinational
// - txd_o      out  1   serial line, idle high
// - tx_int_o   out  1   interrupt request, registered level
// BEHAVIOUR
// - Register map (addr[3:2]):
//   0 TXDATA   W: ce&we&sel[0] pushes data_i[7:0]. Reads as 0.
//   1 STATUS   R: [0] busy (frame in flight), [1] full, [2] empty, [3] overflow (sticky),
//              [8+:CNT_W] FIFO level. Write with sel[0]&data_i[3] clears overflow.
//   2 CTRL     RW: [0] tx_en, [1] irq_en, [2] parity_en (see CONFIGURATION). Byte 0 written only if sel[0].
//   3 BAUDDIV  RW: [15:0] bit period in clk cycles. Bytes 0/1 are written per sel[0]/sel[1]. A value of 0 is treated as 1.
// - Reads: data_o = selected register when ce&~we, else 32'h0. Unused bits read 0.
// - Writes take effect on the posedge where ce&we is sampled high.
// - Reset values: txd_o=1, tx_int_o=0, FIFO empty, overflow=0, CTRL=0, BAUDDIV=DIV_RESET, FSM IDLE.
// - FIFO push to full FIFO: the byte is dropped and overflow is set.
//   - Exception: if a pop occurs in the same cycle, the push is accepted.
// - FIFO pop and push in the same cycle when not full: level unchanged. Pointers wrap modulo FIFO_DEPTH.
// - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE
//   - IDLE: txd_o=1. If tx_en & ~empty, the FSM pops the head into the shift register, latches BAUDDIV into div_q, and moves to START.
//   - START: txd_o=0 for div_q cycles.
//   - DATA: 8 bits, LSB first, div_q cycles each.
//   - STOP: txd_o=1 for div_q cycles. At the end it goes to START directly (back-to-back pop) if tx_en & ~empty, else to IDLE.
// - Bit timer: counts 0..div_q-1. The bit advances on the cycle the count equals div_q-1. BAUDDIV writes mid-frame affect only the next frame.
// - The first txd_o falling edge is 1 cycle after the posedge on which the FIFO goes non-empty (tx_en=1, IDLE).
// - Clearing tx_en mid-frame: the current frame completes, and no new frame starts.
// - busy = (state != IDLE).
// - tx_int_o is registered from irq_en & empty & ~busy, so it lags by 1 cycle.
// - rst mid-frame: the line returns high immediately; FIFO contents are discarded.
// CONFIGURATION
// - UART_TX_PARITY_EN defined:
//   - CTRL[2] is RW.
//   - When CTRL[2] is latched as 1 at frame start, a PARITY state follows DATA. It drives the even parity bit (XOR of the 8 data bits) for div_q cycles.
// - UART_TX_PARITY_EN undefined: CTRL[2] reads 0, writes are ignored, there is no PARITY state, and frames are always 8N1.
// TESTING
// - Reset, then read BAUDDIV/STATUS -> 32'd434 / empty=1, level=0; txd_o=1, tx_int_o=0.
// - BAUDDIV=4, CTRL=1, write 8'hA5 -> txd_o: 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4; total 40 cycles.
// - Push 3 bytes back-to-back with BAUDDIV=2 -> 3 contiguous frames, no idle gap between STOP and START; busy drops after 60 cycles.
// - With tx_en=0, push FIFO_DEPTH+1 bytes -> full=1, overflow=1, level=8. Write STATUS 32'h8 -> overflow=0.
// - CTRL=3, send one byte -> tx_int_o rises 1 cycle after busy falls with FIFO empty. Write CTRL=1 -> tx_int_o=0 the cycle after.
// - With UART_TX_PARITY_EN, CTRL=5, byte 8'h07 -> parity bit 1 before stop, frame 11 bits. Without the macro, CTRL reads back 1.

Source files
------------

// File: rtl/uart_tx_periph.sv
// rtl/uart_tx_periph.sv - memory-mapped UART transmitter with TX FIFO and level interrupt
// Optional even-parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_periph #(
  parameter int          FIFO_DEPTH = 8,
  parameter int          CNT_W      = 4,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        txd_o,
  output logic        tx_int_o
);

  localparam int PTR_W = CNT_W - 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [7:0]         mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               tx_en_q, tx_en_d;
  logic               irq_en_q, irq_en_d;
  logic               par_en_q, par_en_d;
  logic [15:0]        baud_q, baud_d;
  logic [15:0]        div_q, div_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               par_bit_q, par_bit_d;
  logic               par_frame_q, par_frame_d;
  logic               tx_int_q, tx_int_d;

  logic               wr, rd, push, push_ok, pop;
  logic               full, empty, bit_end, busy;
  logic [7:0]         head;
  logic               unused_bits;

  assign wr      = ce & we;
  assign rd      = ce & ~we;
  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign bit_end = (cnt_q == div_q - 16'd1);
  assign push    = wr & (addr[3:2] == 2'd0) & sel[0];
  // A pop frees a slot this very cycle, so a push into a full FIFO still lands.
  assign pop     = ((state_q == S_IDLE) | ((state_q == S_STOP) & bit_end)) & tx_en_q & ~empty;
  assign push_ok = push & (~full | pop);
  assign tx_int_o = tx_int_q;

  assign unused_bits = ^{addr[31:4], addr[1:0], sel[3:2], data_i[31:16], par_frame_q};

  // State and datapath registers, asynchronously reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      tx_en_q     <= 1'b0;
      irq_en_q    <= 1'b0;
      par_en_q    <= 1'b0;
      baud_q      <= DIV_RESET;
      div_q       <= 16'd1;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      par_bit_q   <= 1'b0;
      par_frame_q <= 1'b0;
      tx_int_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      tx_en_q     <= tx_en_d;
      irq_en_q    <= irq_en_d;
      par_en_q    <= par_en_d;
      baud_q      <= baud_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      par_bit_q   <= par_bit_d;
      par_frame_q <= par_frame_d;
      tx_int_q    <= tx_int_d;
    end
  end

  // FIFO storage needs no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Frame sequencing: START, 8 data bits, optional parity, STOP, chaining frames back-to-back
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (tx_en_q && !empty) state_d = S_START;
      S_START:  if (bit_end) state_d = S_DATA;
      S_DATA: begin
        if (bit_end && bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = par_frame_q ? S_PARITY : S_STOP;
`else
          state_d = S_STOP;
`endif
        end
      end
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP:   if (bit_end) state_d = (tx_en_q && !empty) ? S_START : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Serial line, busy flag and combinational register read mux
  always_comb begin
    busy   = (state_q != S_IDLE);
    txd_o  = 1'b1;
    data_o = 32'h0;
    case (state_q)
      S_START:  txd_o = 1'b0;
      S_DATA:   txd_o = shift_q[0];
      S_PARITY: txd_o = par_bit_q;
      default:  txd_o = 1'b1;
    endcase
    if (rd) begin
      case (addr[3:2])
        2'd1: begin
          data_o[0]          = busy;
          data_o[1]          = full;
          data_o[2]          = empty;
          data_o[3]          = ovf_q;
          data_o[8 +: CNT_W] = count_q;
        end
        2'd2:    data_o[2:0]  = {par_en_q, irq_en_q, tx_en_q};
        2'd3:    data_o[15:0] = baud_q;
        default: data_o = 32'h0;
      endcase
    end
  end

  // Bit timer, shifter, FIFO bookkeeping and register writes
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    tx_en_d     = tx_en_q;
    irq_en_d    = irq_en_q;
    par_en_d    = par_en_q;
    baud_d      = baud_q;
    div_d       = div_q;
    cnt_d       = '0;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    par_bit_d   = par_bit_q;
    par_frame_d = par_frame_q;
    tx_int_d    = irq_en_q & empty & (state_q == S_IDLE);

    if (state_q != S_IDLE) cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;

    if (state_q == S_DATA && bit_end) begin
      shift_d   = {1'b0, shift_q[7:1]};
      bit_idx_d = bit_idx_q + 3'd1;
    end

    // Frame start snapshots the byte, the bit period and the parity mode
    if (pop) begin
      shift_d     = head;
      bit_idx_d   = 3'd0;
      div_d       = (baud_q == 16'd0) ? 16'd1 : baud_q;
      par_bit_d   = ^head;
      par_frame_d = par_en_q;
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
    end

    if (push_ok) begin
      mem_d[wr_ptr_q] = data_i[7:0];
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (wr && addr[3:2] == 2'd1 && sel[0] && data_i[3]) ovf_d = 1'b0;
    if (push && !push_ok) ovf_d = 1'b1;

    if (wr && addr[3:2] == 2'd2 && sel[0]) begin
      tx_en_d  = data_i[0];
      irq_en_d = data_i[1];
`ifdef UART_TX_PARITY_EN
      par_en_d = data_i[2];
`else
      par_en_d = 1'b0;
`endif
    end

    if (wr && addr[3:2] == 2'd3) begin
      if (sel[0]) baud_d[7:0]  = data_i[7:0];
      if (sel[1]) baud_d[15:8] = data_i[15:8];
    end
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// tb/tb_uart_tx_periph.sv - self-checking bench for uart_tx_periph against a frame-level line model
module tb_uart_tx_periph;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce, we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        txd_o;
  logic        tx_int_o;

  int errors = 0;
  int checks = 0;

  logic rec = 1'b0;
  logic line_q[$];
  logic irq_q[$];
  logic exp_q[$];

  uart_tx_periph dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
    .data_i(data_i), .data_o(data_o), .txd_o(txd_o), .tx_int_o(tx_int_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rec) begin
      line_q.push_back(txd_o);
      irq_q.push_back(tx_int_o);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    ce = 1'b1; we = 1'b1; addr = {28'h0, r, 2'b00}; sel = s; data_i = d;
    @(posedge clk);
    #1;
    ce = 1'b0; we = 1'b0; sel = 4'h0; data_i = 32'h0;
  endtask

  task automatic bus_read(input logic [1:0] r, output logic [31:0] d);
    @(negedge clk);
    ce = 1'b1; we = 1'b0; addr = {28'h0, r, 2'b00};
    #1;
    d = data_o;
    #1;
    ce = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [1:0] r, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(r, v);
    chk32(tag, v, exp);
  endtask

  // Expected 8N1 (or 8E1) line samples for one byte at d cycles per bit
  task automatic add_frame(input logic [7:0] b, input int d, input logic par);
    repeat (d) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (d) exp_q.push_back(b[i]);
    if (par) repeat (d) exp_q.push_back(^b);
    repeat (d) exp_q.push_back(1'b1);
  endtask

  // Recording starts right after the enabling posedge; the first sample is still idle
  task automatic start_rec();
    line_q.delete();
    irq_q.delete();
    exp_q.delete();
    exp_q.push_back(1'b1);
    rec = 1'b1;
  endtask

  task automatic check_stream(input string tag);
    int  g;
    bit  bad;
    repeat (4) exp_q.push_back(1'b1);
    g = 0;
    while (line_q.size() < exp_q.size() && g < 20000) begin
      @(negedge clk);
      g++;
    end
    #1 rec = 1'b0;
    checks++;
    assert (line_q.size() >= exp_q.size()) else begin
      errors++;
      $error("FAIL %s_len observed=%0d expected=%0d", tag, line_q.size(), exp_q.size());
    end
    bad = 1'b0;
    for (int i = 0; i < exp_q.size() && !bad && i < line_q.size(); i++) begin
      checks++;
      assert (line_q[i] === exp_q[i]) else begin
        errors++;
        bad = 1'b1;
        $error("FAIL %s_txd[%0d] observed=%b expected=%b", tag, i, line_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    logic [7:0]  b;
    logic [7:0]  bytes[$];
    int          d, n, rise;

    rst = 1'b1; ce = 1'b0; we = 1'b0; addr = 32'h0; sel = 4'h0; data_i = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Reset state
    chk32("rst_txd", {31'b0, txd_o}, 32'd1);
    chk32("rst_int", {31'b0, tx_int_o}, 32'd0);
    read_chk("rst_baud", 2'd3, 32'd434);
    read_chk("rst_status", 2'd2 - 2'd1, 32'h0000_0004);
    read_chk("rst_ctrl", 2'd2, 32'h0);
    read_chk("txdata_reads0", 2'd0, 32'h0);

    // Single 0xA5 frame at 4 cycles per bit
    bus_write(2'd3, 32'd4, 4'b0011);
    bus_write(2'd2, 32'd1, 4'b0001);
    bus_write(2'd0, 32'hA5, 4'b0001);
    start_rec();
    add_frame(8'hA5, 4, 1'b0);
    check_stream("a5");
    read_chk("a5_status", 2'd1, 32'h4);

    // Three back-to-back frames at 2 cycles per bit
    bus_write(2'd3, 32'd2, 4'b0011);
    bus_write(2'd0, 32'h3C, 4'b0001);
    start_rec();
    bus_write(2'd0, 32'h81, 4'b0001);
    bus_write(2'd0, 32'hFF, 4'b0001);
    add_frame(8'h3C, 2, 1'b0);
    add_frame(8'h81, 2, 1'b0);
    add_frame(8'hFF, 2, 1'b0);
    check_stream("b2b");
    read_chk("b2b_status", 2'd1, 32'h4);

    // BAUDDIV write mid-frame only affects the following frame
    bus_write(2'd0, 32'h5A, 4'b0001);
    start_rec();
    bus_write(2'd0, 32'hC3, 4'b0001);
    bus_write(2'd3, 32'd3, 4'b0011);
    add_frame(8'h5A, 2, 1'b0);
    add_frame(8'hC3, 3, 1'b0);
    check_stream("middiv");

    // BAUDDIV of 0 reads back 0 and behaves as 1
    bus_write(2'd3, 32'd0, 4'b0011);
    read_chk("div0_read", 2'd3, 32'd0);
    bus_write(2'd0, 32'h96, 4'b0001);
    start_rec();
    add_frame(8'h96, 1, 1'b0);
    check_stream("div0");

    // Random bursts
    for (int k = 0; k < 4; k++) begin
      d = $urandom_range(1, 3);
      n = $urandom_range(1, 4);
      bytes.delete();
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        bytes.push_back(b);
      end
      bus_write(2'd3, 32'(d), 4'b0011);
      bus_write(2'd0, {24'h0, bytes[0]}, 4'b0001);
      start_rec();
      for (int j = 1; j < n; j++) bus_write(2'd0, {24'h0, bytes[j]}, 4'b0001);
      foreach (bytes[j]) add_frame(bytes[j], d, 1'b0);
      check_stream("rand");
    end

    // Overflow with transmitter disabled
    bus_write(2'd2, 32'd0, 4'b0001);
    for (int j = 0; j < 9; j++) bus_write(2'd0, 32'(8'h10 + j), 4'b0001);
    read_chk("ovf_status", 2'd1, 32'h0000_080A);
    bus_write(2'd1, 32'h8, 4'b0001);
    read_chk("ovf_clear", 2'd1, 32'h0000_0802);
    bus_write(2'd3, 32'd1, 4'b0011);
    bus_write(2'd2, 32'd1, 4'b0001);
    start_rec();
    for (int j = 0; j < 8; j++) add_frame(8'(8'h10 + j), 1, 1'b0);
    check_stream("drain");
    read_chk("drain_status", 2'd1, 32'h4);

    // Interrupt timing
    bus_write(2'd2, 32'd0, 4'b0001);
    bus_write(2'd3, 32'd2, 4'b0011);
    bus_write(2'd0, 32'h42, 4'b0001);
    bus_write(2'd2, 32'd3, 4'b0001);
    start_rec();
    add_frame(8'h42, 2, 1'b0);
    check_stream("irq_frame");
    rise = 1 + 10 * 2 + 1;
    for (int i = 0; i < exp_q.size(); i++)
      chk32($sformatf("irq[%0d]", i), {31'b0, irq_q[i]}, {31'b0, (i >= rise)});
    bus_write(2'd2, 32'd1, 4'b0001);
    chk32("irq_hold", {31'b0, tx_int_o}, 32'd1);
    @(posedge clk);
    #1;
    chk32("irq_off", {31'b0, tx_int_o}, 32'd0);

`ifdef UART_TX_PARITY_EN
    bus_write(2'd2, 32'd5, 4'b0001);
    read_chk("ctrl_par", 2'd2, 32'd5);
    bus_write(2'd0, 32'h07, 4'b0001);
    start_rec();
    add_frame(8'h07, 2, 1'b1);
    check_stream("parity");
`else
    bus_write(2'd2, 32'd5, 4'b0001);
    read_chk("ctrl_nopar", 2'd2, 32'd1);
    bus_write(2'd0, 32'h07, 4'b0001);
    start_rec();
    add_frame(8'h07, 2, 1'b0);
    check_stream("noparity");
`endif

    // Reset in the middle of a frame
    bus_write(2'd3, 32'd4, 4'b0011);
    bus_write(2'd2, 32'd1, 4'b0001);
    bus_write(2'd0, 32'h00, 4'b0001);
    bus_write(2'd0, 32'h00, 4'b0001);
    repeat (10) @(negedge clk);
    chk32("midrst_low", {31'b0, txd_o}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk32("midrst_high", {31'b0, txd_o}, 32'd1);
    @(negedge clk) rst = 1'b0;
    read_chk("midrst_status", 2'd1, 32'h4);
    read_chk("midrst_ctrl", 2'd2, 32'h0);
    read_chk("midrst_baud", 2'd3, 32'd434);
    repeat (20) @(negedge clk);
    chk32("midrst_idle", {31'b0, txd_o}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
